// File: rtl/fe_pipe_ctrl_if.sv
// Request/strobe bundle between the IFU stages, backend flush source and fe_pipe_ctrl.
// master drives requests and samples strobes; slave is the controller side.
interface fe_pipe_ctrl_if #(
    parameter int NUM_STAGES = 8,
    parameter int CNT_W      = 32
);
    logic                  bkd_flush_i;
    logic [NUM_STAGES-1:0] stage_pause_req_i;
    logic [NUM_STAGES-1:0] stage_flush_req_i;
    logic                  perf_clr_i;
    logic [NUM_STAGES-1:0] stage_pause_o;
    logic [NUM_STAGES-1:0] stage_flush_o;
    logic                  flush_busy_o;
    logic [CNT_W-1:0]      pause_cycles_o;
    logic [CNT_W-1:0]      flush_events_o;

    modport master (
        output bkd_flush_i, stage_pause_req_i, stage_flush_req_i, perf_clr_i,
        input  stage_pause_o, stage_flush_o, flush_busy_o, pause_cycles_o, flush_events_o
    );

    modport slave (
        input  bkd_flush_i, stage_pause_req_i, stage_flush_req_i, perf_clr_i,
        output stage_pause_o, stage_flush_o, flush_busy_o, pause_cycles_o, flush_events_o
    );
endinterface

// File: rtl/fe_pipe_ctrl.sv
// Front-end pipeline pause/flush control; pause and immediate flush are zero-cycle combinational,
// backend flush to delayed stages lags BKD_DELAY cycles. No backpressure: strobes are pure outputs.
module fe_pipe_ctrl #(
    parameter int                    NUM_STAGES   = 8,
    parameter int                    FLUSH_HOLD   = 2,
    parameter int                    BKD_DELAY    = 1,
    parameter logic [NUM_STAGES-1:0] DELAYED_MASK = NUM_STAGES'(8'b0000_0011),
    parameter int                    CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    fe_pipe_ctrl_if.slave bus
);
    localparam int CMAX     = (FLUSH_HOLD > BKD_DELAY) ? FLUSH_HOLD : BKD_DELAY;
    localparam int CNT_BITS = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {RUN, LFLUSH, BFLUSH} state_t;

    state_t                state, state_n;
    logic [CNT_BITS-1:0]   cnt, cnt_n;
    logic [NUM_STAGES-1:0] hold_mask, hold_mask_n;
    logic [BKD_DELAY-1:0]  dly_sr;
    logic [NUM_STAGES-1:0] flush, pause, up_flush_req, up_pause_req;
    logic                  local_acc, dly_flush;
    logic [CNT_W-1:0]      pause_cnt, event_cnt;

    // Bit i is set when any stage downstream of i (higher index) asserts its bit.
    function automatic logic [NUM_STAGES-1:0] up_mask(input logic [NUM_STAGES-1:0] v);
        logic [NUM_STAGES-1:0] r;
        r = '0;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            r[i] = r[i+1] | v[i+1];
        end
        return r;
    endfunction

    assign up_flush_req = up_mask(bus.stage_flush_req_i);
    assign up_pause_req = up_mask(bus.stage_pause_req_i);
    assign dly_flush    = dly_sr[BKD_DELAY-1];
    assign local_acc    = (|bus.stage_flush_req_i) & ~bus.bkd_flush_i & (state != BFLUSH);

    always_comb begin
        flush = '0;
        if (bus.bkd_flush_i) flush = flush | ~DELAYED_MASK;
        if (dly_flush)       flush = flush | DELAYED_MASK;
        if (local_acc)       flush = flush | up_flush_req;
        if (state == LFLUSH) flush = flush | hold_mask;
        pause = up_pause_req & ~flush;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_mask_n = hold_mask;
        case (state)
            RUN: begin
                if (bus.bkd_flush_i) begin
                    state_n = BFLUSH;
                    cnt_n   = CNT_BITS'(BKD_DELAY);
                end else if (local_acc && (FLUSH_HOLD > 1)) begin
                    state_n     = LFLUSH;
                    cnt_n       = CNT_BITS'(FLUSH_HOLD - 1);
                    hold_mask_n = up_flush_req;
                end
            end
            LFLUSH: begin
                if (bus.bkd_flush_i) begin
                    state_n     = BFLUSH;
                    cnt_n       = CNT_BITS'(BKD_DELAY);
                    hold_mask_n = '0;
                end else if (local_acc) begin
                    // A new redirect restarts the hold and widens the flushed set.
                    cnt_n       = CNT_BITS'(FLUSH_HOLD - 1);
                    hold_mask_n = hold_mask | up_flush_req;
                end else if (cnt == CNT_BITS'(1)) begin
                    state_n     = RUN;
                    cnt_n       = '0;
                    hold_mask_n = '0;
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
            BFLUSH: begin
                if (bus.bkd_flush_i) begin
                    cnt_n = CNT_BITS'(BKD_DELAY);
                end else if (cnt == CNT_BITS'(1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_BITS'(1);
                end
            end
            default: begin
                state_n     = RUN;
                cnt_n       = '0;
                hold_mask_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            hold_mask <= '0;
            dly_sr    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hold_mask <= hold_mask_n;
            dly_sr[0] <= bus.bkd_flush_i;
            for (int i = 1; i < BKD_DELAY; i++) begin
                dly_sr[i] <= dly_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_cnt <= '0;
            event_cnt <= '0;
        end else begin
            if (bus.perf_clr_i)
                pause_cnt <= '0;
            else if ((|bus.stage_pause_req_i) && (flush == '0) && !(&pause_cnt))
                pause_cnt <= pause_cnt + CNT_W'(1);

            if (bus.perf_clr_i)
                event_cnt <= '0;
            else if ((bus.bkd_flush_i || local_acc) && !(&event_cnt))
                event_cnt <= event_cnt + CNT_W'(1);
        end
    end

    assign bus.stage_flush_o  = flush;
    assign bus.stage_pause_o  = pause;
    assign bus.flush_busy_o   = (state != RUN);
    assign bus.pause_cycles_o = pause_cnt;
    assign bus.flush_events_o = event_cnt;
endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// Directed and random bench for fe_pipe_ctrl against a timestamp-based reference model.
module tb_fe_pipe_ctrl;
    localparam int         N  = 8;
    localparam int         FH = 2;
    localparam int         BD = 1;
    localparam logic [7:0] DM = 8'h03;
    localparam int         CW = 4;
    localparam int         CMAXV = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fe_pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(CW)) bus ();

    fe_pipe_ctrl #(
        .NUM_STAGES(N), .FLUSH_HOLD(FH), .BKD_DELAY(BD), .DELAYED_MASK(DM), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: absolute cycle timestamps rather than an FSM.
    int         t;
    int         last_bkd;
    int         hold_end;
    logic [7:0] hold_mask;
    logic       dq[$];
    int         mp, mf;

    logic [7:0]    obs_flush, obs_pause;
    logic          obs_busy;
    logic [CW-1:0] obs_pc, obs_fe;

    function automatic logic [7:0] upm(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (v[j]) r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic mreset();
        last_bkd  = -100;
        hold_end  = -100;
        hold_mask = '0;
        mp        = 0;
        mf        = 0;
        dq.delete();
        for (int i = 0; i < BD; i++) dq.push_back(1'b0);
    endtask

    // Called just after a rising edge; drives one cycle, checks at the falling edge.
    task automatic step(input logic b, input logic [7:0] pr, input logic [7:0] fr, input logic clr);
        logic       bfl, lfl, acc, eb;
        logic [7:0] ef, ep;
        bus.bkd_flush_i       = b;
        bus.stage_pause_req_i = pr;
        bus.stage_flush_req_i = fr;
        bus.perf_clr_i        = clr;
        @(negedge clk);
        bfl = (t - last_bkd) <= BD;
        lfl = (hold_end >= t);
        acc = (fr != 0) && !b && !bfl;
        ef  = '0;
        if (b)     ef = ef | ~DM;
        if (dq[0]) ef = ef | DM;
        if (acc)   ef = ef | upm(fr);
        if (lfl)   ef = ef | hold_mask;
        ep  = upm(pr) & ~ef;
        eb  = bfl || lfl;
        obs_flush = bus.stage_flush_o;
        obs_pause = bus.stage_pause_o;
        obs_busy  = bus.flush_busy_o;
        obs_pc    = bus.pause_cycles_o;
        obs_fe    = bus.flush_events_o;
        chk("flush", 32'(obs_flush), 32'(ef));
        chk("pause", 32'(obs_pause), 32'(ep));
        chk("busy", 32'(obs_busy), 32'(eb));
        chk("pause_cycles", 32'(obs_pc), 32'(mp));
        chk("flush_events", 32'(obs_fe), 32'(mf));
        @(posedge clk);
        if (acc) begin
            hold_mask = lfl ? (hold_mask | upm(fr)) : upm(fr);
            hold_end  = t + FH - 1;
        end
        if (b) begin
            last_bkd = t;
            hold_end = -100;
        end
        if (clr) mp = 0;
        else if (pr != 0 && ef == 0 && mp < CMAXV) mp++;
        if (clr) mf = 0;
        else if ((b || acc) && mf < CMAXV) mf++;
        dq.push_back(b);
        void'(dq.pop_front());
        t++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t = 0;
        mreset();
        rst_n = 1'b0;
        bus.bkd_flush_i = 1'b0;
        bus.stage_pause_req_i = '0;
        bus.stage_flush_req_i = '0;
        bus.perf_clr_i = 1'b0;
        #2;
        chk("rst_flush", 32'(bus.stage_flush_o), 32'h0);
        chk("rst_pause", 32'(bus.stage_pause_o), 32'h0);
        chk("rst_busy", 32'(bus.flush_busy_o), 32'h0);
        chk("rst_pc", 32'(bus.pause_cycles_o), 32'h0);
        chk("rst_fe", 32'(bus.flush_events_o), 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pause propagation
        step(1'b0, 8'h80, 8'h00, 1'b0); chk("pause_80", 32'(obs_pause), 32'h7F);
        step(1'b0, 8'h08, 8'h00, 1'b0); chk("pause_08", 32'(obs_pause), 32'h07);

        // Local flush from stage 5
        step(1'b0, 8'h00, 8'h20, 1'b0); chk("lf_t0", 32'(obs_flush), 32'h1F); chk("lf_busy_t0", 32'(obs_busy), 32'h0);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("lf_t1", 32'(obs_flush), 32'h1F); chk("lf_busy_t1", 32'(obs_busy), 32'h1);
        chk("lf_events", 32'(obs_fe), 32'h1);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("lf_t2", 32'(obs_flush), 32'h00); chk("lf_busy_t2", 32'(obs_busy), 32'h0);

        // Backend flush with pause requested throughout
        step(1'b1, 8'h80, 8'h00, 1'b0); chk("bf_t0", 32'(obs_flush), 32'hFC); chk("bf_pause_t0", 32'(obs_pause), 32'h03);
        step(1'b0, 8'h80, 8'h00, 1'b0); chk("bf_t1", 32'(obs_flush), 32'h03); chk("bf_pause_t1", 32'(obs_pause), 32'h7C);
        step(1'b0, 8'h80, 8'h00, 1'b0); chk("bf_t2", 32'(obs_flush), 32'h00); chk("bf_pause_t2", 32'(obs_pause), 32'h7F);

        // Simultaneous backend + local, then local ignored in BFLUSH
        step(1'b1, 8'h00, 8'h20, 1'b0); chk("sim_t0", 32'(obs_flush), 32'hFC);
        step(1'b0, 8'h00, 8'h20, 1'b0); chk("sim_t1", 32'(obs_flush), 32'h03);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("sim_t2", 32'(obs_flush), 32'h00); chk("sim_busy_t2", 32'(obs_busy), 32'h0);

        // Back-to-back local requests union and extend
        step(1'b0, 8'h00, 8'h20, 1'b0);
        step(1'b0, 8'h00, 8'h80, 1'b0); chk("b2b_t1", 32'(obs_flush), 32'h7F);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("b2b_t2", 32'(obs_flush), 32'h7F);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("b2b_t3", 32'(obs_flush), 32'h00);

        // Counter saturation and clear
        step(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h10, 8'h00, 1'b0);
        chk("pc_sat", 32'(obs_pc), 32'hF);
        step(1'b0, 8'h10, 8'h00, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("pc_clr", 32'(obs_pc), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       b, c;
            logic [7:0] pr, fr;
            b  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 49) == 0);
            pr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            fr = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 15) == 0) fr = 8'($urandom);
            step(b, pr, fr, c);
        end

        // Reset in the middle of a backend flush
        step(1'b1, 8'h00, 8'h00, 1'b0);
        bus.bkd_flush_i = 1'b0;
        bus.stage_pause_req_i = '0;
        bus.stage_flush_req_i = '0;
        bus.perf_clr_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_flush", 32'(bus.stage_flush_o), 32'h0);
        chk("mrst_busy", 32'(bus.flush_busy_o), 32'h0);
        chk("mrst_pc", 32'(bus.pause_cycles_o), 32'h0);
        chk("mrst_fe", 32'(bus.flush_events_o), 32'h0);
        chk("mrst_pause", 32'(bus.stage_pause_o), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        mreset();
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 8'h00, 1'b0); chk("mrst_no_dly", 32'(obs_flush), 32'h0);
        step(1'b0, 8'h40, 8'h00, 1'b0); chk("mrst_pause_after", 32'(obs_pause), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fe_pipe_ctrl.md
# fe_pipe_ctrl

Parametrised front-end pipeline control unit. It collects per-stage pause and flush requests, plus the backend flush, and produces per-stage pause and flush strobes for an N-stage fetch pipeline. Compared with the fixed IFU control unit, it adds:
- generalised upstream stall propagation;
- a counter-based local-redirect flush stretch;
- a configurable delayed backend flush for predictor-style stages;
- a flush-state FSM and saturating performance counters.

It sits between the IFU stages (stage 0 = PC generation, stage N-1 = instruction buffer) and the backend control interface.

## Interface
Parameters:
- NUM_STAGES, 8: number of controlled stages (≥2). Index 0 is most upstream.
- FLUSH_HOLD, 2: cycles a local redirect flush is asserted (≥1).
- BKD_DELAY, 1: cycles of delay for the backend flush to delayed stages (≥1).
- DELAYED_MASK, 8'b0000_0011: bit i set means stage i sees only the delayed backend flush.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bkd_flush_i  in  1  backend flush (mispredict/exception)
- stage_pause_req_i  in  NUM_STAGES  stage i cannot accept new data
- stage_flush_req_i  in  NUM_STAGES  stage i redirects fetch; flushes stages upstream of i
- stage_pause_o  out  NUM_STAGES  hold stage i registers
- stage_flush_o  out  NUM_STAGES  invalidate stage i contents
- flush_busy_o  out  1  FSM not in RUN
- perf_clr_i  in  1  synchronous clear of both counters
- pause_cycles_o  out  CNT_W  saturating count of stalled cycles
- flush_events_o  out  CNT_W  saturating count of accepted flushes

## Operation
- **Upstream mask.** up(v)[i] = OR of v[j] for j>i. Bit N-1 is always 0.
- **Pause.**
  - stage_pause_o[i] = up(stage_pause_req_i)[i] & ~stage_flush_o[i].
  - A stage's own request is not echoed back to itself.
  - Flush has priority over pause.
- **Backend immediate flush.** bkd_flush_i drives stage_flush_o[i] in the same cycle for every i with DELAYED_MASK[i]=0.
- **Backend delayed flush.**
  - A BKD_DELAY-deep shift register carries bkd_flush_i.
  - Its output drives stage_flush_o[i] for every i with DELAYED_MASK[i]=1.
- **Local flush.**
  - Accepted only when bkd_flush_i=0 and state≠BFLUSH. Otherwise it is ignored.
  - In the cycle it is accepted, stage_flush_o |= up(stage_flush_req_i). This applies regardless of DELAYED_MASK.
  - hold_mask is ORed into stage_flush_o while in LFLUSH.
- **FSM** (states RUN, LFLUSH, BFLUSH):
  - RUN:
    - bkd_flush_i → BFLUSH, cnt=BKD_DELAY.
    - else an accepted local request with FLUSH_HOLD>1 → LFLUSH, cnt=FLUSH_HOLD-1, hold_mask=up(req).
  - LFLUSH:
    - bkd_flush_i → BFLUSH, cnt=BKD_DELAY, hold_mask=0.
    - else a new local request → cnt=FLUSH_HOLD-1, hold_mask|=up(req).
    - else cnt-=1; when cnt==1 → RUN and hold_mask=0.
  - BFLUSH:
    - bkd_flush_i reloads cnt=BKD_DELAY.
    - else cnt-=1; when cnt==1 → RUN.
    - Local requests are ignored.
- **flush_busy_o** = (state≠RUN), registered.
- **pause_cycles_o** increments when |stage_pause_req_i and stage_flush_o==0. It saturates at all-ones.
- **flush_events_o** increments each cycle that bkd_flush_i=1 or a local request is accepted. It saturates at all-ones.
- **Counter priority:** perf_clr_i beats increment, so the next value is 0.

## Timing
- **Reset values:**
  - state=RUN; cnt, hold_mask and the shift register all 0.
  - Counters 0 and flush_busy_o=0.
  - stage_pause_o and stage_flush_o are 0 whenever inputs are 0.
- **Combinational latency:**
  - Pause and immediate flush paths have zero-cycle latency.
  - A local flush spans exactly FLUSH_HOLD cycles from the request cycle, counting the request cycle.
- **Delayed flush latency:**
  - The delayed backend flush appears exactly BKD_DELAY cycles after bkd_flush_i.
  - A k-cycle backend pulse produces a k-cycle delayed pulse.
- **Back-to-back requests:**
  - A repeated local request extends the hold from the latest request.
  - Masks union; they do not replace each other.
- **Simultaneous events:**
  - When backend and local requests arrive in the same cycle, the backend flush wins.
  - The local request is not counted.
- **Reset mid-flush:** asserting rst_n low clears the state and the delay line immediately, with no residual delayed flush.

## Test plan
Defaults for all scenarios: N=8, FLUSH_HOLD=2, BKD_DELAY=1, DELAYED_MASK=8'h03.

1. **Reset.** rst_n low mid-BFLUSH, inputs 0 → all outputs 0, busy=0, counters 0. No delayed flush follows.
2. **Pause propagation.** stage_pause_req_i=8'h80 → stage_pause_o=8'h7F in the same cycle. Changing to 8'h08 → 8'h07.
3. **Local flush.** stage_flush_req_i[5] pulsed at t → stage_flush_o=8'h1F at t and t+1, 8'h00 at t+2. busy=1 at t+1 only. flush_events_o=1.
4. **Backend flush.** bkd_flush_i pulsed at t → stage_flush_o=8'hFC at t, 8'h03 at t+1, 8'h00 at t+2. Pause is masked during these cycles.
5. **Simultaneous and ignored requests.** bkd_flush_i and stage_flush_req_i[5] both at t → stage_flush_o 8'hFC at t, 8'h03 at t+1, no hold. A local request at t+1 is ignored.
6. **Counter saturation and clear.** CNT_W=4, stage_pause_req_i=8'h10 held for 20 cycles → pause_cycles_o=15. Then perf_clr_i asserted together with the pause → 0 next cycle.
